fetch_decode_stage: RTL and testbench

Instruction fetch and decode front-end placed directly upstream of the register file. It sequences the PC and handles a request/acknowledge handshake with instruction memory. It latches each fetched instruction into an output register and decodes that instruction into the register-file read/write addresses, the register-write enable and the immediate. It supports downstream stall, PC redirect, and one-entry skid buffering so that no fetched word is lost.

---
 rtl/riscv_pkg.sv | 38 +++
 rtl/imm_gen.sv | 36 +++
 rtl/fetch_decode_stage.sv | 130 +++++++++++++
 tb/tb_fetch_decode_stage.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// ---------------------------------------------------------------------------
// riscv_pkg
// Shared definitions for the fetch/decode front-end: RV32 base opcodes, the
// fetch sequencer state encoding, the canonical NOP word, and a helper that
// tells whether an opcode writes the destination register.
// ---------------------------------------------------------------------------
package riscv_pkg;

    // RV32I base opcodes (instr[6:0])
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;

    // Fetch sequencer states
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_FETCH   = 2'd1;
    localparam logic [1:0] ST_SKID    = 2'd2;
    localparam logic [1:0] ST_DISCARD = 2'd3;

    // addi x0, x0, 0
    localparam logic [31:0] NOP = 32'h0000_0013;

    // True for the opcodes whose result lands in rd.
    function automatic logic writes_rd(input logic [6:0] opcode);
        case (opcode)
            OP_LUI, OP_AUIPC, OP_JAL, OP_JALR,
            OP_LOAD, OP_IMM, OP_OP: return 1'b1;
            default:                return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/imm_gen.sv
// ---------------------------------------------------------------------------
// imm_gen
// Purely combinational immediate extractor. Selects the I/S/B/U/J format from
// the opcode and produces the sign-extended 32-bit immediate; opcodes without
// an immediate give 0.
// Ports:
//   instr  in   32  instruction word
//   imm    out  32  sign-extended immediate
// ---------------------------------------------------------------------------
module imm_gen
    import riscv_pkg::*;
(
    input  logic [31:0] instr,
    output logic [31:0] imm
);

    always_comb begin
        // NOTE: assigning a default first means every path drives imm, so no latch is inferred.
        imm = '0;
        case (instr[6:0])
            OP_LOAD, OP_IMM, OP_JALR:
                imm = {{20{instr[31]}}, instr[31:20]};
            OP_STORE:
                imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            OP_BRANCH:
                imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            OP_LUI, OP_AUIPC:
                imm = {instr[31:12], 12'b0};
            OP_JAL:
                imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default:
                imm = '0;
        endcase
    end

endmodule

// File: rtl/fetch_decode_stage.sv
// ---------------------------------------------------------------------------
// fetch_decode_stage
// Instruction fetch sequencer plus decode register feeding the register file.
// Issues request/acknowledge fetches to instruction memory, captures each
// returned word into an output register, and decodes register addresses,
// write enable and immediate from it. A one-entry skid holds a word that
// arrives while the output is stalled; a redirect squashes in-flight work and
// restarts fetching at the new target.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   imemReq/imemAddr      fetch request and address (out)
//   imemAck/imemData      one-cycle acknowledge with instruction word (in)
//   stall                 downstream cannot consume the output this cycle
//   redirect/redirectPc   one-cycle restart request and target
//   valid/pcOut/instrOut  output register
//   readReg1/readReg2/writeReg/regWrite/imm  decode of instrOut
// ---------------------------------------------------------------------------
module fetch_decode_stage
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          XLEN     = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imemReq,
    output logic [XLEN-1:0] imemAddr,
    input  logic            imemAck,
    input  logic [XLEN-1:0] imemData,
    input  logic            stall,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirectPc,
    output logic            valid,
    output logic [XLEN-1:0] pcOut,
    output logic [XLEN-1:0] instrOut,
    output logic [4:0]      readReg1,
    output logic [4:0]      readReg2,
    output logic [4:0]      writeReg,
    output logic            regWrite,
    output logic [XLEN-1:0] imm
);

    logic [1:0]      state;
    logic [XLEN-1:0] fetch_pc;     // next address to fetch (redirect target while discarding)
    logic [XLEN-1:0] discard_pc;   // address of the abandoned request, held until its ack
    logic [XLEN-1:0] skid_instr;
    logic [XLEN-1:0] skid_pc;
    logic            slot_free;

    assign slot_free = !valid || !stall;

    // An issued request cannot be withdrawn, so DISCARD keeps presenting the
    // old address until memory acknowledges it.
    assign imemReq  = (state == ST_FETCH) || (state == ST_DISCARD);
    assign imemAddr = (state == ST_DISCARD) ? discard_pc : fetch_pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the skid is only a handful of flops, so it is reset along with the rest of the state.
            state      <= ST_IDLE;
            valid      <= 1'b0;
            pcOut      <= '0;
            instrOut   <= '0;
            skid_instr <= '0;
            skid_pc    <= '0;
            fetch_pc   <= RESET_PC;
            discard_pc <= RESET_PC;
        end else if (redirect) begin
            // NOTE: non-blocking assignments so every branch reads pre-edge state.
            valid    <= 1'b0;
            fetch_pc <= redirectPc & ~32'h3;
            if (state == ST_FETCH && !imemAck) begin
                state      <= ST_DISCARD;
                discard_pc <= fetch_pc;
            end else if (state == ST_DISCARD && !imemAck) begin
                state <= ST_DISCARD;
            end else begin
                state <= ST_FETCH;
            end
        end else begin
            // Consumed output empties unless a new word is loaded below.
            if (valid && !stall) begin
                valid <= 1'b0;
            end
            case (state)
                ST_IDLE: state <= ST_FETCH;
                ST_FETCH: begin
                    if (imemAck) begin
                        fetch_pc <= fetch_pc + 32'd4;
                        if (slot_free) begin
                            pcOut    <= fetch_pc;
                            instrOut <= imemData;
                            valid    <= 1'b1;
                        end else begin
                            skid_pc    <= fetch_pc;
                            skid_instr <= imemData;
                            state      <= ST_SKID;
                        end
                    end
                end
                ST_SKID: begin
                    if (slot_free) begin
                        pcOut    <= skid_pc;
                        instrOut <= skid_instr;
                        valid    <= 1'b1;
                        state    <= ST_FETCH;
                    end
                end
                ST_DISCARD: begin
                    if (imemAck) begin
                        state <= ST_FETCH;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Decode of the output register
    assign readReg1 = instrOut[19:15];
    assign readReg2 = instrOut[24:20];
    assign writeReg = instrOut[11:7];
    assign regWrite = valid && (instrOut[11:7] != 5'd0) && writes_rd(instrOut[6:0]);

    imm_gen u_imm_gen (
        .instr (instrOut),
        .imm   (imm)
    );

endmodule

// File: tb/tb_fetch_decode_stage.sv
// ---------------------------------------------------------------------------
// tb_fetch_decode_stage
// Self-checking bench: a transaction-level model of the fetch front-end is
// compared against the DUT every cycle, a directed sequence walks the main
// scenarios with literal expectations, then randomized traffic follows.
// ---------------------------------------------------------------------------
module tb_fetch_decode_stage;
    import riscv_pkg::*;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        imemReq;
    logic [31:0] imemAddr;
    logic        imemAck = 1'b0;
    logic [31:0] imemData = '0;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirectPc = '0;
    logic        valid;
    logic [31:0] pcOut;
    logic [31:0] instrOut;
    logic [4:0]  readReg1;
    logic [4:0]  readReg2;
    logic [4:0]  writeReg;
    logic        regWrite;
    logic [31:0] imm;

    int checks   = 0;
    int failures = 0;

    fetch_decode_stage #(.RESET_PC(RESET_PC), .XLEN(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .imemReq    (imemReq),
        .imemAddr   (imemAddr),
        .imemAck    (imemAck),
        .imemData   (imemData),
        .stall      (stall),
        .redirect   (redirect),
        .redirectPc (redirectPc),
        .valid      (valid),
        .pcOut      (pcOut),
        .instrOut   (instrOut),
        .readReg1   (readReg1),
        .readReg2   (readReg2),
        .writeReg   (writeReg),
        .regWrite   (regWrite),
        .imm        (imm)
    );

    always #5 clk = ~clk;

    // ---------------- instruction memory contents ----------------
    logic [31:0] mem [logic [31:0]];

    function automatic logic [31:0] rand_instr();
        logic [6:0]  ops [11];
        logic [31:0] w;
        ops = '{OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD,
                OP_STORE, OP_IMM, OP_OP, 7'b0001111, 7'b1111111};
        w = $urandom;
        w[6:0] = ops[$urandom_range(0, 10)];
        if ($urandom_range(0, 3) == 0) w[11:7] = 5'd0;
        return w;
    endfunction

    function automatic logic [31:0] get_word(input logic [31:0] addr);
        if (!mem.exists(addr)) mem[addr] = rand_instr();
        return mem[addr];
    endfunction

    // ---------------- decode reference ----------------
    function automatic logic ref_rw(input logic [31:0] w);
        return (w[11:7] != 5'd0) &&
               (w[6:0] inside {7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111,
                               7'b0000011, 7'b0010011, 7'b0110011});
    endfunction

    // Immediate rebuilt as a weighted sum of fields with a negative sign weight.
    function automatic logic [31:0] ref_imm(input logic [31:0] w);
        int v;
        v = 0;
        case (w[6:0])
            7'b0000011, 7'b0010011, 7'b1100111:
                v = int'(w[30:20]) - (w[31] ? 2048 : 0);
            7'b0100011:
                v = int'(w[30:25]) * 32 + int'(w[11:7]) - (w[31] ? 2048 : 0);
            7'b1100011:
                v = int'(w[7]) * 2048 + int'(w[30:25]) * 32 + int'(w[11:8]) * 2
                    - (w[31] ? 4096 : 0);
            7'b0110111, 7'b0010111:
                v = int'(w & 32'hFFFF_F000);
            7'b1101111:
                v = int'(w[19:12]) * 4096 + int'(w[20]) * 2048 + int'(w[30:21]) * 2
                    - (w[31] ? (1 << 20) : 0);
            default: v = 0;
        endcase
        return 32'(v);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level model ----------------
    bit          m_idle, m_req, m_drop, m_out_v, m_held;
    logic [31:0] m_req_addr, m_next, m_out_pc, m_held_pc;

    task automatic model_reset();
        m_idle = 1; m_req = 0; m_drop = 0; m_out_v = 0; m_held = 0;
        m_next = RESET_PC; m_req_addr = RESET_PC; m_out_pc = '0; m_held_pc = '0;
    endtask

    task automatic model_advance();
        bit          slot_free, ack_now, consume;
        logic [31:0] target;
        slot_free = !m_out_v || !stall;
        consume   = m_out_v && !stall;
        ack_now   = imemAck && m_req;
        target    = {redirectPc[31:2], 2'b00};
        if (redirect) begin
            m_out_v = 0; m_held = 0; m_idle = 0;
            if (m_req && !ack_now) m_drop = 1;   // old request stays on the bus
            else begin m_drop = 0; m_req = 1; m_req_addr = target; end
            m_next = target;
        end else if (m_idle) begin
            m_idle = 0; m_req = 1; m_req_addr = m_next;
        end else if (m_held) begin
            if (slot_free) begin
                m_out_v = 1; m_out_pc = m_held_pc; m_held = 0;
                m_req = 1; m_req_addr = m_next;
            end
        end else if (m_req) begin
            if (consume) m_out_v = 0;
            if (ack_now) begin
                if (m_drop) begin
                    m_drop = 0; m_req_addr = m_next;
                end else begin
                    if (slot_free) begin m_out_v = 1; m_out_pc = m_req_addr; end
                    else begin m_held = 1; m_held_pc = m_req_addr; m_req = 0; end
                    m_next = m_next + 32'd4;
                    m_req_addr = m_next;
                end
            end
        end
    endtask

    // Compare on the falling edge, then advance the model with this cycle's inputs.
    initial begin
        model_reset();
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                model_reset();
                check("rst_valid", valid, 0);
                check("rst_imemReq", imemReq, 0);
                check("rst_pcOut", pcOut, 0);
                check("rst_instrOut", instrOut, 0);
            end else begin
                logic [31:0] w;
                check("imemReq", imemReq, m_req);
                if (m_req) check("imemAddr", imemAddr, m_req_addr);
                check("valid", valid, m_out_v);
                if (m_out_v) begin
                    w = get_word(m_out_pc);
                    check("pcOut", pcOut, m_out_pc);
                    check("instrOut", instrOut, w);
                    check("readReg1", readReg1, w[19:15]);
                    check("readReg2", readReg2, w[24:20]);
                    check("writeReg", writeReg, w[11:7]);
                    check("regWrite", regWrite, ref_rw(w));
                    check("imm", imm, ref_imm(w));
                end else begin
                    check("regWrite_idle", regWrite, 0);
                end
                model_advance();
            end
        end
    end

    // Wait for an edge, then drive inputs for the coming cycle; ack only when requested.
    task automatic step(input bit want_ack, input bit st, input bit rd, input logic [31:0] rpc);
        @(posedge clk);
        #1;
        imemAck    = want_ack && imemReq;
        imemData   = imemAck ? get_word(imemAddr) : $urandom;
        stall      = st;
        redirect   = rd;
        redirectPc = rpc;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        mem[32'h0] = 32'h0050_0093;   // addi x1, x0, 5
        mem[32'h4] = 32'h0020_A223;   // sw   x2, 4(x1)
        mem[32'h8] = NOP;

        // Pin the reference decode against hand-computed values.
        check("pin_imm_addi", ref_imm(32'h0050_0093), 32'd5);
        check("pin_imm_sw",   ref_imm(32'h0020_A223), 32'd4);
        check("pin_imm_beq",  ref_imm(32'h0020_8463), 32'd8);
        check("pin_imm_jal",  ref_imm(32'hFFDF_F0EF), 32'hFFFF_FFFC);
        check("pin_imm_lui",  ref_imm(32'h1234_52B7), 32'h1234_5000);
        check("pin_rw_sw",    ref_rw(32'h0020_A223), 0);
        check("pin_rw_addi",  ref_rw(32'h0050_0093), 1);

        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        #1 check("d_idle_noreq", imemReq, 0);

        // Back-to-back fetches and decode
        step(1, 0, 0, 0);  #1 check("d_addr0", imemAddr, 32'h0);
        check("d_req0", imemReq, 1);
        step(1, 0, 0, 0);  #1 check("d_valid0", valid, 1);
        check("d_pc0", pcOut, 32'h0);
        check("d_addi_rr1", readReg1, 0);
        check("d_addi_wr", writeReg, 1);
        check("d_addi_rw", regWrite, 1);
        check("d_addi_imm", imm, 32'd5);
        check("d_addr4", imemAddr, 32'h4);
        step(1, 0, 0, 0);  #1 check("d_pc4", pcOut, 32'h4);
        check("d_sw_rr1", readReg1, 1);
        check("d_sw_rr2", readReg2, 2);
        check("d_sw_rw", regWrite, 0);
        check("d_sw_imm", imm, 32'd4);
        check("d_addr8", imemAddr, 32'h8);
        // Word at 0xC arrives while the output is stalled
        step(1, 1, 0, 0);  #1 check("d_pc8", pcOut, 32'h8);
        check("d_nop_rw", regWrite, 0);
        step(0, 0, 0, 0);  #1 check("d_skid_noreq", imemReq, 0);
        check("d_skid_hold", instrOut, NOP);
        check("d_skid_pc", pcOut, 32'h8);
        // Skid drains; request back at 0x10, then redirect while it is outstanding
        step(0, 0, 1, 32'h200);  #1 check("d_skid_out", pcOut, 32'hC);
        check("d_refetch", imemReq, 1);
        check("d_addr10", imemAddr, 32'h10);
        step(0, 0, 0, 0);  #1 check("d_disc_addr", imemAddr, 32'h10);
        check("d_disc_valid", valid, 0);
        step(1, 0, 0, 0);  #1 check("d_disc_addr2", imemAddr, 32'h10);
        // Ack and a redirect to 0x103 in the same cycle
        step(1, 0, 1, 32'h103);  #1 check("d_addr200", imemAddr, 32'h200);
        check("d_after_disc_valid", valid, 0);
        step(1, 0, 1, 32'hFFFF_FFFC);  #1 check("d_addr100", imemAddr, 32'h100);
        check("d_redir_ack_valid", valid, 0);
        step(1, 1, 0, 0);  #1 check("d_addr_top", imemAddr, 32'hFFFF_FFFC);
        step(1, 1, 0, 0);  #1 check("d_pc_top", pcOut, 32'hFFFF_FFFC);
        check("d_wrap", imemAddr, 32'h0);
        // Stalled ack sends the word to the skid; reset lands mid-cycle
        step(0, 1, 0, 0);  #1 check("d_skid2_noreq", imemReq, 0);
        #1 rst_n = 1'b0;
        #1 check("d_async_valid", valid, 0);
        check("d_async_req", imemReq, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        stall = 1'b0;
        #1 check("d_rel_idle", imemReq, 0);
        step(0, 0, 0, 0);  #1 check("d_rel_addr", imemAddr, RESET_PC);
        check("d_rel_req", imemReq, 1);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 499) == 0) begin
                @(posedge clk);
                #1 rst_n = 1'b0;
                imemAck = 0; stall = 0; redirect = 0;
                repeat (2) @(posedge clk);
                #1 rst_n = 1'b1;
            end else begin
                logic [31:0] rpc;
                rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                  : $urandom;
                step($urandom_range(0, 9) < 6, $urandom_range(0, 9) < 3,
                     $urandom_range(0, 19) == 0, rpc);
            end
        end
        @(posedge clk);
        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
